sram_swc_bus_adapter: RTL

Request/response adapter that sits directly upstream of sram_swc and is its only driver.
- Converts a byte-addressed valid/ready load/store interface into sram_swc's single-port, whole-word accesses.
- Implements byte-strobed writes as an internal read-modify-write (RMW).
- Flags misaligned and out-of-range requests without touching the SRAM.

---
 rtl/sram_swc_bus_adapter_pkg.sv | 23 ++
 rtl/sram_swc_byte_merge.sv | 16 +
 rtl/sram_swc_bus_adapter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sram_swc_bus_adapter_pkg.sv
// Shared state encoding, strobe width and request address checks for the
// sram_swc bus adapter and its byte-strobed helpers.
package sram_swc_bus_adapter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int STRB_WIDTH     = DATA_WIDTH_DEF / 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACCESS  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  // A request is rejected when it is not word aligned or when any byte-address
  // bit above the SRAM's word index is set.
  function automatic logic addr_err(input logic [63:0] byte_addr,
                                    input int unsigned word_addr_width);
    logic [63:0] above;
    above = byte_addr >> (word_addr_width + 32'd2);
    return (byte_addr[1:0] != 2'b00) || (above != 64'd0);
  endfunction

endpackage

// File: rtl/sram_swc_byte_merge.sv
// Combinational byte merge: each strobed byte takes the new data, every other
// byte keeps the old word's value.
module sram_swc_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_byte
    assign merged[8*i +: 8] = strb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
  end

endmodule

// File: rtl/sram_swc_bus_adapter.sv
// Byte-addressed valid/ready load/store front end for sram_swc; partial-strobe
// writes become an internal read-modify-write, bad addresses never reach the SRAM.
module sram_swc_bus_adapter
  import sram_swc_bus_adapter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int REQ_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [REQ_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      sram_we,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_wdata,
  input  logic [DATA_WIDTH-1:0]     sram_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [2:0]            state;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] merged;

  logic accept;
  logic req_err;
  logic full_strb;
  logic no_strb;

  assign accept    = req_valid && req_ready;
  assign req_err   = addr_err(64'(req_addr), int'(unsigned'(ADDR_WIDTH)));
  assign full_strb = &req_wstrb;
  assign no_strb   = ~|req_wstrb;

  // The old word comes straight from the SRAM in RD_WAIT, so the merged word is
  // written back whole in one cycle and a reset can never leave it torn.
  sram_swc_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_merge (
    .old_data (sram_rdata),
    .new_data (wdata_q),
    .strb     (wstrb_q),
    .merged   (merged)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wr_q      <= req_we;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            if (req_err) begin
              rsp_err <= 1'b1;
              state   <= ST_RESP;
            end else if (req_we && no_strb) begin
              state <= ST_RESP;
            end else begin
              sram_addr <= req_addr[ADDR_WIDTH+1:2];
              if (req_we && full_strb) begin
                sram_we    <= 1'b1;
                sram_wdata <= req_wdata;
              end
              state <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          sram_we <= 1'b0;
          state   <= (wr_q && (&wstrb_q)) ? ST_RESP : ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (wr_q) begin
            sram_wdata <= merged;
            sram_we    <= 1'b1;
            state      <= ST_WRITE;
          end else begin
            rsp_rdata <= sram_rdata;
            state     <= ST_RESP;
          end
        end

        ST_WRITE: begin
          sram_we <= 1'b0;
          state   <= ST_RESP;
        end

        ST_RESP: begin
          // First cycle in RESP raises rsp_valid; it then holds until taken.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          sram_we   <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
